axi_stream_strip_header: RTL and testbench

//  Receive-side counterpart of the header inserter. Removes a leading header of hdr_len bytes from each
//  AXI-Stream packet and presents it on a side channel. The remaining payload is re-packed so it starts at

---
 rtl/axis_strip_pkg.sv | 36 +++
 rtl/axis_byte_merge.sv | 28 ++
 rtl/axi_stream_strip_header.sv | 158 +++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_strip_pkg.sv
// Shared types and keep/count helpers for the AXI-Stream header stripper.
// Helpers work on a MAX_BYTES-wide keep; callers size-cast results to their beat width.
package axis_strip_pkg;

    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [7:0] keep2cnt(input logic [MAX_BYTES-1:0] keep);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < MAX_BYTES; i++) c = c + {7'd0, keep[i]};
        return c;
    endfunction

    function automatic logic [MAX_BYTES-1:0] cnt2keep_msb(input logic [7:0] cnt, input int bw);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if (i < bw && i >= bw - int'(cnt)) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [MAX_BYTES-1:0] cnt2keep_lsb(input logic [7:0] cnt, input int bw);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if (i < bw && i < int'(cnt)) k[i] = 1'b1;
        return k;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational re-packer: {residual, beat} shifted left by n bytes gives the output word;
// the low (BW-n) bytes of the beat become the next residual.
module axis_byte_merge
    import axis_strip_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic [DATA_WD-1:0] residual,
    input  logic [DATA_WD-1:0] beat,
    input  logic [7:0]         n,
    output logic [DATA_WD-1:0] word,
    output logic [DATA_WD-1:0] next_residual
);
    localparam int BW = DATA_WD / 8;

    logic [2*DATA_WD-1:0] shifted;
    logic [BW-1:0]        res_keep;

    always_comb begin
        shifted       = {residual, beat} << (8 * int'(n));
        word          = shifted[2*DATA_WD-1 -: DATA_WD];
        res_keep      = BW'(cnt2keep_lsb(8'(BW) - n, BW));
        next_residual = '0;
        for (int i = 0; i < BW; i++)
            next_residual[i*8 +: 8] = beat[i*8 +: 8] & {8{res_keep[i]}};
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips an hdr_len-byte header from each AXI-Stream packet onto a side channel and re-packs the payload.
// Optional STRIP_HDR_ERR_EN adds an err_short pulse for short packets or out-of-range hdr_len.
module axi_stream_strip_header
    import axis_strip_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(DATA_BYTE_WD):0] hdr_len,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [DATA_WD-1:0]            data_in,
    input  logic [DATA_BYTE_WD-1:0]       keep_in,
    input  logic                          last_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [DATA_WD-1:0]            data_out,
    output logic [DATA_BYTE_WD-1:0]       keep_out,
    output logic                          last_out,
    output logic                          valid_header,
    input  logic                          ready_header,
    output logic [DATA_WD-1:0]            header_out,
    output logic [DATA_BYTE_WD-1:0]       keep_header,
`ifdef STRIP_HDR_ERR_EN
    output logic                          err_short,
`endif
    output logic [1:0]                    state_dbg
);
    localparam int BW = DATA_BYTE_WD;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a registered valid holds its data stable until that edge.
    state_t               state, state_nxt;
    logic [7:0]           cnt, n_in, n_reg, n_cur, hdr_cnt, pay_cnt, flush_cnt;
    logic                 hdr_bad, pay_free, hdr_free, accept, pay_load, pay_last;
    logic [DATA_WD-1:0]   res_reg, res_nxt, merge_res, merge_beat, pay_word, pay_data, hdr_data;
    logic [BW-1:0]        pay_keep, hdr_keep;

    assign cnt      = keep2cnt(MAX_BYTES'(keep_in));
    assign hdr_bad  = (hdr_len == '0) || (8'(hdr_len) > 8'(BW));
    assign n_in     = hdr_bad ? 8'(BW) : 8'(hdr_len);
    assign n_cur    = (state == HDR) ? n_in : n_reg;
    assign pay_free = !valid_out || ready_out;
    assign hdr_free = !valid_header || ready_header;
    assign accept   = valid_in && ready_in;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR:   if (accept && !last_in) state_nxt = BODY;
            BODY:  if (accept && last_in) state_nxt = (cnt <= n_reg) ? HDR : FLUSH;
            FLUSH: if (pay_free) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    always_comb begin
        ready_in   = 1'b0;
        pay_load   = 1'b0;
        pay_last   = 1'b0;
        pay_cnt    = 8'(BW);
        merge_res  = res_reg;
        merge_beat = data_in;
        case (state)
            HDR: begin
                // Single-beat packet: the merge sees the beat as its own residual.
                ready_in  = pay_free && hdr_free;
                merge_res = data_in;
                pay_last  = 1'b1;
                pay_cnt   = cnt - n_in;
                pay_load  = valid_in && ready_in && last_in && (cnt > n_in);
            end
            BODY: begin
                ready_in = pay_free;
                pay_load = valid_in && ready_in;
                if (last_in && cnt <= n_reg) begin
                    pay_last = 1'b1;
                    pay_cnt  = 8'(BW) - n_reg + cnt;
                end
            end
            FLUSH: begin
                merge_beat = '0;
                pay_last   = 1'b1;
                pay_cnt    = flush_cnt;
                pay_load   = pay_free;
            end
            default: ;
        endcase
    end

    axis_byte_merge #(.DATA_WD(DATA_WD)) u_merge (
        .residual      (merge_res),
        .beat          (merge_beat),
        .n             (n_cur),
        .word          (pay_word),
        .next_residual (res_nxt)
    );

    always_comb begin
        hdr_cnt  = (cnt < n_in) ? cnt : n_in;
        hdr_keep = BW'(cnt2keep_lsb(hdr_cnt, BW));
        hdr_data = data_in >> (DATA_WD - 8 * int'(hdr_cnt));
        pay_keep = BW'(cnt2keep_msb(pay_cnt, BW));
        pay_data = '0;
        for (int i = 0; i < BW; i++)
            pay_data[i*8 +: 8] = pay_word[i*8 +: 8] & {8{pay_keep[i]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            header_out   <= '0;
            keep_header  <= '0;
            n_reg        <= 8'(BW);
            res_reg      <= '0;
            flush_cnt    <= '0;
        end else begin
            if (pay_load) begin
                valid_out <= 1'b1;
                data_out  <= pay_data;
                keep_out  <= pay_keep;
                last_out  <= pay_last;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
            if (accept && state == HDR) begin
                valid_header <= 1'b1;
                header_out   <= hdr_data;
                keep_header  <= hdr_keep;
                n_reg        <= n_in;
            end else if (ready_header) begin
                valid_header <= 1'b0;
            end
            if (accept) res_reg <= res_nxt;
            if (accept && state == BODY && last_in && cnt > n_reg) flush_cnt <= cnt - n_reg;
        end
    end

`ifdef STRIP_HDR_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_short <= 1'b0;
        else        err_short <= accept && (state == HDR) && (hdr_bad || (last_in && cnt < n_in));
    end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-level packet model fills expected queues,
// monitors pop and compare on every payload/header transfer.
module tb_axi_stream_strip_header;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int PW = 1 + BW + DW;
    localparam int HW = BW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [2:0]    hdr_len = '0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [DW-1:0] data_in = '0;
    logic [BW-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          valid_header;
    logic          ready_header = 1'b1;
    logic [DW-1:0] header_out;
    logic [BW-1:0] keep_header;
    logic [1:0]    state_dbg;
`ifdef STRIP_HDR_ERR_EN
    logic          err_short;
`endif

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hdr_len      (hdr_len),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .valid_header (valid_header),
        .ready_header (ready_header),
        .header_out   (header_out),
        .keep_header  (keep_header),
`ifdef STRIP_HDR_ERR_EN
        .err_short    (err_short),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            bp_mode = 0;
    int            exp_err = 0;
    int            err_seen = 0;
    logic [PW-1:0] exp_pay_q[$];
    logic [HW-1:0] exp_hdr_q[$];
    logic [7:0]    pb[0:63];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ready generators: 0 = always ready, 1 = random, 2 = held off
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin
                    ready_out    = ($urandom_range(0, 3) != 0);
                    ready_header = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    ready_out    = 1'b0;
                    ready_header = 1'b0;
                end
                default: begin
                    ready_out    = 1'b1;
                    ready_header = 1'b1;
                end
            endcase
        end
    end

    // ---------------- scoreboard monitors ----------------
    logic          pay_hold = 1'b0;
    logic          hdr_hold = 1'b0;
    logic [PW-1:0] pay_held;
    logic [HW-1:0] hdr_held;

    always @(negedge clk) begin
        if (!rst_n) begin
            pay_hold = 1'b0;
            hdr_hold = 1'b0;
        end else begin
            if (pay_hold)
                check("pay_stable", 64'({valid_out, last_out, keep_out, data_out}), 64'({1'b1, pay_held}));
            if (hdr_hold)
                check("hdr_stable", 64'({valid_header, keep_header, header_out}), 64'({1'b1, hdr_held}));
            if (valid_out && ready_out) begin
                if (exp_pay_q.size() == 0) check("pay_extra", 64'(1), 64'(0));
                else check("payload", 64'({last_out, keep_out, data_out}), 64'(exp_pay_q.pop_front()));
            end
            if (valid_header && ready_header) begin
                if (exp_hdr_q.size() == 0) check("hdr_extra", 64'(1), 64'(0));
                else check("header", 64'({keep_header, header_out}), 64'(exp_hdr_q.pop_front()));
            end
            pay_hold = valid_out && !ready_out;
            pay_held = {last_out, keep_out, data_out};
            hdr_hold = valid_header && !ready_header;
            hdr_held = {keep_header, header_out};
`ifdef STRIP_HDR_ERR_EN
            if (err_short) err_seen++;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [2:0] hl, input logic [DW-1:0] d, input logic [BW-1:0] k,
                              input logic l);
        int  waited;
        bit  done;
        valid_in = 1'b1;
        hdr_len  = hl;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        waited   = 0;
        done     = 0;
        while (!done) begin
            @(negedge clk);
            if (ready_in) done = 1;
            else begin
                waited++;
                if (waited > 2000) begin
                    check("in_timeout", 64'(0), 64'(1));
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Model computes header/payload from the byte list pb[0..len-1], then drives the beats.
    task automatic send_pkt(input logic [2:0] hl, input int len);
        int            n, hcnt, plen, nb, hli;
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        hli  = int'(hl);
        n    = (hli == 0 || hli > BW) ? BW : hli;
        hcnt = (len < n) ? len : n;
        d = '0;
        k = '0;
        for (int i = 0; i < hcnt; i++) begin
            d[(hcnt-1-i)*8 +: 8] = pb[i];
            k[hcnt-1-i] = 1'b1;
        end
        exp_hdr_q.push_back({k, d});
        plen = len - n;
        for (int b = 0; b * BW < plen; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < BW; j++)
                if (b * BW + j < plen) begin
                    d[(BW-1-j)*8 +: 8] = pb[n + b*BW + j];
                    k[BW-1-j] = 1'b1;
                end
            exp_pay_q.push_back({((b + 1) * BW >= plen), k, d});
        end
        if (hli == 0 || hli > BW || len < n) exp_err++;
        nb = (len + BW - 1) / BW;
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            k = '0;
            for (int j = 0; j < BW; j++)
                if (b * BW + j < len) begin
                    d[(BW-1-j)*8 +: 8] = pb[b*BW + j];
                    k[BW-1-j] = 1'b1;
                end
            drive_beat((b == 0) ? hl : 3'($urandom_range(0, 7)), d, k, (b == nb - 1));
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pb[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((exp_pay_q.size() != 0 || exp_hdr_q.size() != 0 || valid_out || valid_header)
               && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 5000) check("drain_timeout", 64'(0), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] hl;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_valid_header", 64'(valid_header), 64'(0));
        check("rst_data_out", 64'({last_out, keep_out, data_out}), 64'(0));
        check("rst_header_out", 64'({keep_header, header_out}), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // N=4, three beats, last keep 1100
        fill_random(10);
        send_pkt(3'd4, 10);
        // N=3, AABBCCDD 11223344 -> FLUSH beat
        pb[0] = 8'hAA; pb[1] = 8'hBB; pb[2] = 8'hCC; pb[3] = 8'hDD;
        pb[4] = 8'h11; pb[5] = 8'h22; pb[6] = 8'h33; pb[7] = 8'h44;
        send_pkt(3'd3, 8);
        // N=1, last beat keep 1000 -> no FLUSH
        fill_random(9);
        send_pkt(3'd1, 9);
        // single-beat short packet
        fill_random(1);
        send_pkt(3'd2, 1);
        // exact-header single beat, and out-of-range hdr_len values
        fill_random(4);
        send_pkt(3'd4, 4);
        fill_random(6);
        send_pkt(3'd0, 6);
        fill_random(3);
        send_pkt(3'd7, 3);
        wait_drain();

        // random back-pressure, random N and lengths
        bp_mode = 1;
        for (int p = 0; p < 1000; p++) begin
            hl = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
            fill_random(16);
            send_pkt(hl, $urandom_range(1, 16));
        end
        bp_mode = 0;
        wait_drain();

        // reset in mid-BODY with valid_out held high
        bp_mode = 2;
        @(posedge clk);
        #1;
        drive_beat(3'd4, 32'h01020304, 4'hF, 1'b0);
        drive_beat(3'd4, 32'h05060708, 4'hF, 1'b0);
        @(negedge clk);
        check("pre_rst_valid_out", 64'(valid_out), 64'(1));
        check("pre_rst_valid_header", 64'(valid_header), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", 64'(valid_out), 64'(0));
        check("mid_rst_valid_header", 64'(valid_header), 64'(0));
        check("mid_rst_state", 64'(state_dbg), 64'(0));
        exp_pay_q.delete();
        exp_hdr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bp_mode = 0;
        @(posedge clk);
        #1;
        pb[0] = 8'hAA; pb[1] = 8'hBB; pb[2] = 8'hCC; pb[3] = 8'hDD;
        pb[4] = 8'h11; pb[5] = 8'h22; pb[6] = 8'h33; pb[7] = 8'h44;
        send_pkt(3'd3, 8);
        wait_drain();

        check("pay_q_empty", 64'(exp_pay_q.size()), 64'(0));
        check("hdr_q_empty", 64'(exp_hdr_q.size()), 64'(0));
`ifdef STRIP_HDR_ERR_EN
        check("err_short_count", 64'(err_seen), 64'(exp_err));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
